result_serializer: RTL and testbench
====================================

Name: result_serializer

Overview:
- Downstream stage of the convolution accelerator core.
- Captures each full output set (DATA_OF_SET results, presented with a one-cycle valid pulse) into a small set FIFO.
- Streams the captured sets out LANES elements per beat over a valid/ready interface, toward the writeback/DMA path.
- The core has no backpressure, so this block absorbs bursts and flags any set it is forced to drop.

Parameters:
- DATA_WIDTH, 4, bits per result element.
- DATA_OF_SET, 36, elements per input set; must be divisible by LANES.
- LANES, 4, elements per output beat. BEATS = DATA_OF_SET/LANES (default 9).
- DEPTH, 2, number of whole sets buffered; power of two, ≥2.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-low reset.
- din_valid  input  1  one-cycle pulse; din holds a complete set.
- din  input  [DATA_OF_SET][DATA_WIDTH]  result set; element 0 is at index 0.
- dout  output  [LANES][DATA_WIDTH]  current beat; lane k = element beat*LANES+k of the head set.
- dout_valid  output  1  beat available.
- dout_ready  input  1  consumer accepts the beat when dout_valid && dout_ready.
- dout_last  output  1  high with dout_valid on beat BEATS-1 of a set.
- level  output  $clog2(DEPTH+1)  number of sets stored, including a partially drained set.
- overflow  output  1  sticky; set when a din_valid set is dropped.

Behaviour:
- Reset (rst=0 at a clock edge):
  - wr_ptr, rd_ptr, beat counter and level go to 0; overflow goes to 0.
  - dout_valid=0, dout_last=0, dout=0.
  - Storage contents are don't-care.
  - Reset mid-stream discards all buffered sets and any partial drain. The first beat after reset comes from the next set written.
- Write:
  - A set is accepted on din_valid=1 when level<DEPTH, or when level==DEPTH and a pop completes in the same cycle.
  - Accept stores din into mem[wr_ptr] and advances wr_ptr modulo DEPTH.
  - Otherwise the set is dropped: overflow←1, and no state other than overflow changes.
- Read:
  - dout_valid = (level!=0).
  - dout is a combinational slice of mem[rd_ptr] selected by beat. dout is forced to 0 when dout_valid=0.
  - On handshake (dout_valid && dout_ready): beat←beat+1. If beat==BEATS-1, beat←0, rd_ptr advances modulo DEPTH, and a pop completes.
  - dout_valid and dout must stay stable while dout_ready=0.
- Level:
  - Increments on accept without pop.
  - Decrements on pop without accept.
  - Unchanged on both or neither.
- Latency: a set accepted at edge N gives dout_valid=1 with beat 0 in the cycle after edge N, when the FIFO was empty.
- Throughput:
  - One beat per cycle at full dout_ready.
  - Sets back-to-back with no bubble between the last beat of one set and beat 0 of the next.
- Pointer wrap-around is modulo DEPTH. level distinguishes full from empty.
- Arithmetic: no data transformation; elements pass bit-exact.

Test Plan:
- Single set, no backpressure:
  - Stimulus: reset, then din[i]=i mod 16 with one din_valid pulse, dout_ready=1.
  - Response: 9 consecutive beats. Beat 0 = {0,1,2,3}, beat 8 = {0,1,2,3} (elements 32..35 mod 16). dout_last only on beat 8. level 1→0 after beat 8.
- Backpressure hold:
  - Stimulus: one set, dout_ready=0 for 5 cycles at beat 3, then 1.
  - Response: dout holds elements 12..15 and dout_valid holds 1 throughout the stall; sequence resumes with no beat skipped or duplicated.
- Fill and overflow:
  - Stimulus: dout_ready=0; din_valid pulses with sets A, B, C.
  - Response: level=2, overflow=1 after C. Releasing ready yields exactly A then B (18 beats); C never appears.
- Simultaneous pop and write at full:
  - Stimulus: level=2, dout_ready=1; din_valid with set D in the same cycle as the last beat of A.
  - Response: D accepted, overflow stays 0, level stays 2. Output order A, B, D; wr_ptr/rd_ptr wrap correctly.
- Reset mid-drain:
  - Stimulus: rst=0 for 1 cycle at beat 4 of a set.
  - Response: next cycle dout_valid=0, dout=0, level=0, overflow=0. A new set then starts at beat 0.
- Back-to-back sets:
  - Stimulus: sets E, F written 2 cycles apart, dout_ready=1.
  - Response: 18 contiguous valid beats; F beat 0 immediately follows E beat 8 with no bubble.

Source files
------------

// File: rtl/result_serializer_if.sv
// result_serializer_if: set input and beat stream handshake between the core, serializer and writeback path.
interface result_serializer_if #(
  parameter int DATA_WIDTH  = 4,
  parameter int DATA_OF_SET = 36,
  parameter int LANES       = 4
);
  logic                                   din_valid;
  logic [DATA_OF_SET-1:0][DATA_WIDTH-1:0] din;
  logic [LANES-1:0][DATA_WIDTH-1:0]       dout;
  logic                                   dout_valid;
  logic                                   dout_ready;
  logic                                   dout_last;
  modport master (output din_valid, din, dout_ready, input dout, dout_valid, dout_last);
  modport slave  (input din_valid, din, dout_ready, output dout, dout_valid, dout_last);
endinterface

// File: rtl/result_serializer.sv
// result_serializer: buffers whole result sets in a small FIFO and streams them out LANES elements per beat.
module result_serializer #(
  parameter int DATA_WIDTH  = 4,
  parameter int DATA_OF_SET = 36,
  parameter int LANES       = 4,
  parameter int DEPTH       = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  result_serializer_if.slave           bus,
  output logic [$clog2(DEPTH+1)-1:0]   level,
  output logic                         overflow
);
  localparam int BEATS = DATA_OF_SET / LANES;
  localparam int AW = $clog2(DEPTH);
  localparam int BW = $clog2(BEATS + 1);
  localparam int LW = $clog2(DEPTH + 1);
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);
  localparam logic [LW-1:0] FULL = LW'(DEPTH);

  typedef logic [DATA_OF_SET-1:0][DATA_WIDTH-1:0] set_t;

  set_t          mem_q [DEPTH];
  set_t          head;
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [BW-1:0] beat_q, beat_d;
  logic [LW-1:0] level_q, level_d;
  logic          ovf_q, ovf_d;
  logic          valid, hs, pop, acc;

  // A full FIFO still accepts when its head set finishes draining this cycle.
  always_comb begin
    valid   = level_q != '0;
    hs      = valid && bus.dout_ready;
    pop     = hs && beat_q == LAST_BEAT;
    acc     = bus.din_valid && (level_q < FULL || pop);
    wr_d    = acc ? wr_q + 1'b1 : wr_q;
    rd_d    = pop ? rd_q + 1'b1 : rd_q;
    beat_d  = pop ? '0 : hs ? beat_q + 1'b1 : beat_q;
    level_d = (acc && !pop) ? level_q + 1'b1 : (pop && !acc) ? level_q - 1'b1 : level_q;
    ovf_d   = ovf_q || (bus.din_valid && !acc);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_q    <= '0;
      rd_q    <= '0;
      beat_q  <= '0;
      level_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      beat_q  <= beat_d;
      level_q <= level_d;
      ovf_q   <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (acc) mem_q[wr_q] <= bus.din;
  end

  assign head           = mem_q[rd_q];
  assign bus.dout       = valid ? head[int'(beat_q) * LANES +: LANES] : '0;
  assign bus.dout_valid = valid;
  assign bus.dout_last  = valid && beat_q == LAST_BEAT;
  assign level          = level_q;
  assign overflow       = ovf_q;
endmodule

// File: tb/tb_result_serializer.sv
// tb_result_serializer: directed scenarios checked every cycle against a set-queue model plus literal anchors.
module tb_result_serializer;
  typedef logic [35:0][3:0] set_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] level;
  logic       overflow;
  int         vectors = 0;
  int         miscompares = 0;
  int         run;

  result_serializer_if #(.DATA_WIDTH(4), .DATA_OF_SET(36), .LANES(4)) bus ();

  result_serializer #(.DATA_WIDTH(4), .DATA_OF_SET(36), .LANES(4), .DEPTH(2)) dut (
    .clk(clk), .rst(rst), .bus(bus), .level(level), .overflow(overflow)
  );

  always #5 clk = ~clk;

  function automatic set_t mk(int base);
    set_t s;
    for (int i = 0; i < 36; i++) s[i] = 4'((i + base) % 16);
    return s;
  endfunction

  function void chk(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  set_t q[$];
  int   mbeat = 0;
  bit   movf = 0;

  // Model: a queue of whole sets, head set drained beat by beat.
  always @(posedge clk) begin
    bit m_hs, m_pop, m_acc;
    if (!rst) begin
      q.delete();
      mbeat = 0;
      movf = 0;
    end else begin
      m_hs  = q.size() != 0 && bus.dout_ready;
      m_pop = m_hs && mbeat == 8;
      m_acc = bus.din_valid && (q.size() < 2 || m_pop);
      if (m_pop) begin
        void'(q.pop_front());
        mbeat = 0;
      end else if (m_hs) mbeat++;
      if (m_acc) q.push_back(bus.din);
      else if (bus.din_valid) movf = 1;
    end
  end

  always @(negedge clk) begin
    set_t        h;
    logic [15:0] ed;
    bit          ev;
    ev = q.size() != 0;
    ed = '0;
    if (ev) begin
      h = q[0];
      for (int k = 0; k < 4; k++) ed[k*4 +: 4] = h[mbeat*4 + k];
    end
    chk("dout_valid", 32'(bus.dout_valid), 32'(ev));
    chk("dout", 32'(bus.dout), 32'(ed));
    chk("dout_last", 32'(bus.dout_last), 32'(ev && mbeat == 8));
    chk("level", 32'(level), 32'(q.size()));
    chk("overflow", 32'(overflow), 32'(movf));
  end

  task automatic cyc(int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic push(set_t s);
    bus.din = s;
    bus.din_valid = 1'b1;
    cyc(1);
    bus.din_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    bus.din_valid = 1'b0;
    bus.din = '0;
    bus.dout_ready = 1'b1;
    cyc(2);
    rst = 1'b1;
    chk("rst_valid", 32'(bus.dout_valid), 0);
    chk("rst_dout", 32'(bus.dout), 0);
    chk("rst_level", 32'(level), 0);

    push(mk(0));
    chk("t1_beat0", 32'(bus.dout), 32'h3210);
    chk("t1_last0", 32'(bus.dout_last), 0);
    cyc(8);
    chk("t1_beat8", 32'(bus.dout), 32'h3210);
    chk("t1_last8", 32'(bus.dout_last), 1);
    chk("t1_level8", 32'(level), 1);
    cyc(1);
    chk("t1_level_end", 32'(level), 0);

    push(mk(0));
    cyc(3);
    bus.dout_ready = 1'b0;
    cyc(5);
    chk("t2_hold", 32'(bus.dout), 32'hFEDC);
    chk("t2_valid", 32'(bus.dout_valid), 1);
    bus.dout_ready = 1'b1;
    cyc(6);
    chk("t2_drained", 32'(bus.dout_valid), 0);

    bus.dout_ready = 1'b0;
    push(mk(1));
    push(mk(5));
    push(mk(9));
    chk("t3_level", 32'(level), 2);
    chk("t3_overflow", 32'(overflow), 1);
    chk("t3_headA", 32'(bus.dout), 32'h4321);
    bus.dout_ready = 1'b1;
    cyc(18);
    chk("t3_empty", 32'(level), 0);

    rst = 1'b0;
    cyc(1);
    rst = 1'b1;
    bus.dout_ready = 1'b0;
    push(mk(1));
    push(mk(5));
    bus.dout_ready = 1'b1;
    cyc(8);
    chk("t4_lastA", 32'(bus.dout_last), 1);
    push(mk(13));
    chk("t4_level", 32'(level), 2);
    chk("t4_overflow", 32'(overflow), 0);
    chk("t4_headB", 32'(bus.dout), 32'h8765);
    cyc(18);
    chk("t4_empty", 32'(level), 0);

    push(mk(2));
    cyc(4);
    rst = 1'b0;
    cyc(1);
    rst = 1'b1;
    chk("t5_valid", 32'(bus.dout_valid), 0);
    chk("t5_dout", 32'(bus.dout), 0);
    chk("t5_level", 32'(level), 0);
    chk("t5_overflow", 32'(overflow), 0);
    push(mk(0));
    chk("t5_beat0", 32'(bus.dout), 32'h3210);
    cyc(9);

    push(mk(3));
    run = 0;
    for (int i = 0; i < 30; i++) begin
      bus.din = mk(7);
      bus.din_valid = (i == 1);
      if (!bus.dout_valid) break;
      run++;
      cyc(1);
    end
    bus.din_valid = 1'b0;
    chk("t6_run", 32'(run), 18);

    cyc(2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
